// File: rtl/dual_wave_gen.sv
// dual_wave_gen: two-channel 2-bit periodic waveform source.
//
// Feeds the in1/in2 operand streams of the signal-summing stage. Each channel
// has its own shape code and step divider, written over a valid/ready port.
// A run/idle/load state machine gates the outputs so the consumer sees 2'b00
// whenever generation is stopped.
//
// Optional feature macro: WAVE_SYNC_EN
//   defined   - leaving LOAD restarts both channels (keeps them phase-aligned)
//   undefined - leaving LOAD restarts only the channel that was written; the
//               other channel simply holds for the single LOAD cycle
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   level: 1 = generate, 0 = idle
//   cfg_valid  in   configuration word present
//   cfg_ready  out  configuration can be accepted (low only in LOAD)
//   cfg_sel    in   target channel: 0 = channel 1, 1 = channel 2
//   cfg_shape  in   shape: 00 square, 01 staircase, 10 triangle, 11 off
//   cfg_div    in   step divider; one step lasts cfg_div+1 cycles
//   wave1      out  channel 1 sample, registered
//   wave2      out  channel 2 sample, registered

module dual_wave_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_sel,
  input  logic [1:0]       cfg_shape,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [1:0]       wave1,
  output logic [1:0]       wave2
);

  localparam int unsigned NCH     = 2;
  localparam int unsigned SHAPE_W = 2;
  localparam int unsigned PHASE_W = 3;
  localparam int unsigned SMP_W   = 2;

  localparam logic [SHAPE_W-1:0] SHAPE_SQUARE = 2'b00;
  localparam logic [SHAPE_W-1:0] SHAPE_STAIR  = 2'b01;
  localparam logic [SHAPE_W-1:0] SHAPE_TRI    = 2'b10;
  localparam logic [SHAPE_W-1:0] SHAPE_OFF    = 2'b11;

`ifdef WAVE_SYNC_EN
  localparam bit SYNC_RESTART = 1'b1;
`else
  localparam bit SYNC_RESTART = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t state, state_nx;

  // Per-channel registers, index 0 = channel 1, index 1 = channel 2
  logic [NCH-1:0][SHAPE_W-1:0] shape_q, shape_nx;
  logic [NCH-1:0][DIV_W-1:0]   div_q,   div_nx;
  logic [NCH-1:0][DIV_W-1:0]   cnt_q,   cnt_nx;
  logic [NCH-1:0][PHASE_W-1:0] phase_q, phase_nx;
  logic [NCH-1:0][SMP_W-1:0]   wave_q,  wave_nx;
  logic                        load_sel_q, load_sel_nx;

  // Control decoded by the state machine
  logic           accept;
  logic           do_step;
  logic           clr_all;
  logic           clr_wave;
  logic [NCH-1:0] restart;

  // Sample value for a given shape and phase
  function automatic logic [SMP_W-1:0] sample_of(input logic [SHAPE_W-1:0] shape,
                                                 input logic [PHASE_W-1:0] phase);
    logic [SMP_W-1:0] smp;
    smp = '0;
    case (shape)
      SHAPE_SQUARE: smp = (phase == 3'd0) ? 2'b11 : 2'b00;
      SHAPE_STAIR:  smp = phase[SMP_W-1:0];
      SHAPE_TRI: begin
        case (phase)
          3'd0:    smp = 2'd0;
          3'd1:    smp = 2'd1;
          3'd2:    smp = 2'd2;
          3'd3:    smp = 2'd3;
          3'd4:    smp = 2'd2;
          3'd5:    smp = 2'd1;
          default: smp = 2'd0;
        endcase
      end
      default:      smp = '0;
    endcase
    return smp;
  endfunction

  // Phase after one step; wraps at the shape length, off stays frozen at 0
  function automatic logic [PHASE_W-1:0] next_phase(input logic [SHAPE_W-1:0] shape,
                                                    input logic [PHASE_W-1:0] phase);
    logic [PHASE_W-1:0] last;
    last = '0;
    case (shape)
      SHAPE_SQUARE: last = 3'd1;
      SHAPE_STAIR:  last = 3'd3;
      SHAPE_TRI:    last = 3'd5;
      default:      last = 3'd0;
    endcase
    return (phase >= last) ? '0 : phase + PHASE_W'(1);
  endfunction

  assign cfg_ready = (state != S_LOAD);
  assign wave1     = wave_q[0];
  assign wave2     = wave_q[1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and datapath control
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    do_step  = 1'b0;
    clr_all  = 1'b0;
    clr_wave = 1'b0;
    restart  = '0;

    case (state)
      S_IDLE: begin
        accept = cfg_valid;
        if (accept) begin
          state_nx = S_LOAD;
        end else if (enable) begin
          state_nx = S_RUN;
          clr_all  = 1'b1;
        end
      end
      S_RUN: begin
        accept = cfg_valid;
        if (enable) begin
          do_step = 1'b1;
        end else begin
          clr_all  = 1'b1;
          clr_wave = 1'b1;
        end
        if (accept) begin
          state_nx = S_LOAD;
        end else if (!enable) begin
          state_nx = S_IDLE;
        end
      end
      S_LOAD: begin
        if (enable) begin
          state_nx = S_RUN;
          if (SYNC_RESTART) begin
            restart = '1;
          end else begin
            restart = load_sel_q ? 2'b10 : 2'b01;
          end
        end else begin
          state_nx = S_IDLE;
          clr_all  = 1'b1;
          clr_wave = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Per-channel next values; stepping uses the pre-edge shape and phase
  always_comb begin
    shape_nx    = shape_q;
    div_nx      = div_q;
    cnt_nx      = cnt_q;
    phase_nx    = phase_q;
    wave_nx     = wave_q;
    load_sel_nx = load_sel_q;

    if (accept) begin
      load_sel_nx = cfg_sel;
    end

    for (int unsigned ch = 0; ch < NCH; ch++) begin
      if (accept && (cfg_sel == 1'(ch))) begin
        shape_nx[ch] = cfg_shape;
        div_nx[ch]   = cfg_div;
      end

      if (do_step) begin
        wave_nx[ch] = sample_of(shape_q[ch], phase_q[ch]);
        if (cnt_q[ch] == div_q[ch]) begin
          cnt_nx[ch]   = '0;
          phase_nx[ch] = next_phase(shape_q[ch], phase_q[ch]);
        end else begin
          cnt_nx[ch] = cnt_q[ch] + DIV_W'(1);
        end
      end

      if (clr_all || restart[ch]) begin
        cnt_nx[ch]   = '0;
        phase_nx[ch] = '0;
      end

      if (clr_wave) begin
        wave_nx[ch] = '0;
      end
    end
  end

  // Channel registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shape_q    <= {NCH{SHAPE_OFF}};
      div_q      <= '0;
      cnt_q      <= '0;
      phase_q    <= '0;
      wave_q     <= '0;
      load_sel_q <= 1'b0;
    end else begin
      shape_q    <= shape_nx;
      div_q      <= div_nx;
      cnt_q      <= cnt_nx;
      phase_q    <= phase_nx;
      wave_q     <= wave_nx;
      load_sel_q <= load_sel_nx;
    end
  end

endmodule

// File: tb/tb_dual_wave_gen.sv
// tb_dual_wave_gen: directed self-checking bench for dual_wave_gen.
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_dual_wave_gen;

  localparam int unsigned DIV_W = 8;

`ifdef WAVE_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             enable    = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_sel   = 1'b0;
  logic [1:0]       cfg_shape = 2'b00;
  logic [DIV_W-1:0] cfg_div   = '0;
  logic             cfg_ready;
  logic [1:0]       wave1;
  logic [1:0]       wave2;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_sq  [8] = '{3, 3, 0, 0, 3, 3, 0, 0};
  int exp_st  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_tri [6] = '{0, 1, 2, 3, 2, 1};

  always #5 clk = ~clk;

  dual_wave_gen #(.DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_shape (cfg_shape),
    .cfg_div   (cfg_div),
    .wave1     (wave1),
    .wave2     (wave2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, expect it accepted at the next edge, then LOAD
  task automatic cfg_word(input logic sel, input logic [1:0] shape, input logic [DIV_W-1:0] div);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_shape = shape;
    cfg_div   = div;
    check("cfg_ready_before_accept", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    check("cfg_ready_in_load", 32'(cfg_ready), 32'd0);
  endtask

  initial begin
    // Reset values
    #1;
    check("rst_wave1", 32'(wave1), 32'd0);
    check("rst_wave2", 32'(wave2), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;

    // Default shapes are off: outputs stay zero while running
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("dflt_wave1", 32'(wave1), 32'd0);
      check("dflt_wave2", 32'(wave2), 32'd0);
      check("dflt_ready", 32'(cfg_ready), 32'd1);
    end

    // ch1 square div 1, ch2 staircase div 0, loaded while idle
    enable = 1'b0;
    tick();
    cfg_word(1'b0, 2'b00, 8'd1);
    tick();
    cfg_word(1'b1, 2'b01, 8'd0);
    tick();
    enable = 1'b1;
    tick();
    check("entry_wave1", 32'(wave1), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("sq_wave1", 32'(wave1), 32'(exp_sq[i]));
      check("st_wave2", 32'(wave2), 32'(exp_st[i]));
    end

    // Drop enable mid-step, then re-enable
    enable = 1'b0;
    tick();
    check("drop_wave1", 32'(wave1), 32'd0);
    check("drop_wave2", 32'(wave2), 32'd0);
    enable = 1'b1;
    tick();
    check("reen_e0_wave1", 32'(wave1), 32'd0);
    tick();
    check("reen_e1_wave1", 32'(wave1), 32'd3);
    check("reen_e1_wave2", 32'(wave2), 32'd0);

    // cfg_valid held 3 cycles with distinct words: only words 1 and 3 land
    cfg_valid = 1'b1;
    cfg_sel   = 1'b0;
    cfg_shape = 2'b10;
    cfg_div   = 8'd2;
    check("burst_ready_c1", 32'(cfg_ready), 32'd1);
    tick();
    cfg_sel   = 1'b1;
    cfg_shape = 2'b11;
    cfg_div   = 8'd5;
    check("burst_ready_c2", 32'(cfg_ready), 32'd0);
    tick();
    cfg_sel   = 1'b1;
    cfg_shape = 2'b00;
    cfg_div   = 8'd0;
    check("burst_ready_c3", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    check("burst_ready_load", 32'(cfg_ready), 32'd0);
    tick();
    tick();
    check("burst_wave2_a", 32'(wave2), 32'd3);
    tick();
    check("burst_wave2_b", 32'(wave2), 32'd0);
    tick();
    check("burst_wave2_c", 32'(wave2), 32'd3);

    // Triangle div 2 on ch1 from a clean restart, ch2 square div 0
    enable = 1'b0;
    tick();
    check("tri_idle_wave1", 32'(wave1), 32'd0);
    enable = 1'b1;
    tick();
    check("tri_e0_wave1", 32'(wave1), 32'd0);
    for (int i = 0; i < 21; i++) begin
      tick();
      check("tri_wave1", 32'(wave1), 32'(exp_tri[(i / 3) % 6]));
      check("sq0_wave2", 32'(wave2), (i % 2 == 0) ? 32'd3 : 32'd0);
    end

    // Reconfigure ch2 while ch1 runs staircase div 0
    enable = 1'b0;
    tick();
    cfg_word(1'b0, 2'b01, 8'd0);
    tick();
    cfg_word(1'b1, 2'b00, 8'd1);
    tick();
    enable = 1'b1;
    tick();
    tick();
    check("rc_pre_wave1_a", 32'(wave1), 32'd0);
    tick();
    check("rc_pre_wave1_b", 32'(wave1), 32'd1);
    cfg_word(1'b1, 2'b00, 8'd0);
    check("rc_accept_wave1", 32'(wave1), 32'd2);
    tick();
    check("rc_load_hold_wave1", 32'(wave1), 32'd2);
    tick();
    check("rc_after1_wave1", 32'(wave1), SYNC ? 32'd0 : 32'd3);
    check("rc_after1_wave2", 32'(wave2), 32'd3);
    tick();
    check("rc_after2_wave1", 32'(wave1), SYNC ? 32'd1 : 32'd0);
    check("rc_after2_wave2", 32'(wave2), 32'd0);

    // Switch ch2 to off while running
    cfg_word(1'b1, 2'b11, 8'd0);
    check("off_accept_wave2", 32'(wave2), 32'd3);
    tick();
    check("off_load_wave2", 32'(wave2), 32'd3);
    tick();
    check("off_after1_wave2", 32'(wave2), 32'd0);
    tick();
    check("off_after2_wave2", 32'(wave2), 32'd0);

    // Maximum divider: 256-cycle steps, 512-cycle square period
    enable = 1'b0;
    tick();
    cfg_word(1'b0, 2'b00, 8'd255);
    tick();
    enable = 1'b1;
    tick();
    tick();
    check("max_first_wave1", 32'(wave1), 32'd3);
    for (int i = 0; i < 255; i++) tick();
    check("max_last_high_wave1", 32'(wave1), 32'd3);
    check("max_wave2_off", 32'(wave2), 32'd0);
    tick();
    check("max_first_low_wave1", 32'(wave1), 32'd0);
    for (int i = 0; i < 255; i++) tick();
    check("max_last_low_wave1", 32'(wave1), 32'd0);
    tick();
    check("max_period_wave1", 32'(wave1), 32'd3);

    // Asynchronous reset mid-run takes effect immediately
    rst_n = 1'b0;
    #1;
    check("arst_wave1", 32'(wave1), 32'd0);
    check("arst_ready", 32'(cfg_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_arst_wave1", 32'(wave1), 32'd0);
    check("post_arst_wave2", 32'(wave2), 32'd0);
    check("post_arst_ready", 32'(cfg_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
